// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and helpers for the SPI slave core
package spi_pkg;

   // FSM state encoding
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   // SPI modes as {CPOL, CPHA}
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   // Bit counter must hold values 0..data_w
   function automatic int cnt_width(input int data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with rise/fall pulse outputs
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the asynchronous input through the chain and keep a delayed copy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign q    = sync_q[SYNC_STAGES-1];
   assign rise = q & ~prev_q;
   assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - oversampling full-duplex SPI slave with tx holding register
module spi_slave_core
   import spi_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int MSB_FIRST   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   input  logic              spi_cs,
   output logic              spi_miso,
   output logic              miso_oe,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_ready,
   output logic              tx_underrun,
   output logic              frame_err,
   output logic              busy
);

   localparam int         CNT_W       = cnt_width(DATA_W);
   localparam logic [1:0] MODE        = {1'(CPOL != 0), 1'(CPHA != 0)};
   localparam logic       IDLE_HIGH   = (MODE == SPI_MODE2) || (MODE == SPI_MODE3);
   localparam logic       LATE_SAMPLE = (MODE == SPI_MODE1) || (MODE == SPI_MODE3);
   localparam logic       MSB_F       = (MSB_FIRST != 0);

   logic sclk_s, sclk_rise, sclk_fall;
   logic cs_s, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic mosi_s;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk  (clk),
      .rst  (rst),
      .d    (spi_sclk),
      .q    (sclk_s),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .clk  (clk),
      .rst  (rst),
      .d    (spi_cs),
      .q    (cs_s),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   // MOSI gets the same depth as SCLK so data and clock stay aligned
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mosi_sync_q <= '0;
      else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
   end
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // After a leading edge SCLK sits at the non-idle level
   logic sclk_edge, leading_edge, trailing_edge, sample_edge, shift_edge;
   assign sclk_edge     = sclk_rise | sclk_fall;
   assign leading_edge  = sclk_edge & (sclk_s != IDLE_HIGH);
   assign trailing_edge = sclk_edge & (sclk_s == IDLE_HIGH);
   assign sample_edge   = LATE_SAMPLE ? trailing_edge : leading_edge;
   assign shift_edge    = LATE_SAMPLE ? leading_edge  : trailing_edge;

   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic              rx_valid_q, rx_valid_d;
   logic              underrun_q, underrun_d;
   logic              und_pend_q, und_pend_d;
   logic              frame_err_q, frame_err_d;
   logic              load_pend_q, load_pend_d;
   logic              skip_q, skip_d;

   logic [DATA_W-1:0] rx_next, tx_shifted;
   logic              do_load;

   // Next-state: FSM, sampling, shifting, word loads and holding register
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      rx_data_d   = rx_data_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rx_valid_d  = 1'b0;
      underrun_d  = 1'b0;
      und_pend_d  = und_pend_q;
      frame_err_d = 1'b0;
      load_pend_d = load_pend_q;
      skip_d      = skip_q;
      do_load     = 1'b0;
      rx_next     = MSB_F ? {rx_shift_q[DATA_W-2:0], mosi_s} : {mosi_s, rx_shift_q[DATA_W-1:1]};
      tx_shifted  = MSB_F ? {tx_shift_q[DATA_W-2:0], 1'b0} : {1'b0, tx_shift_q[DATA_W-1:1]};

      if (tx_load && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (cs_rise) begin
               state_d    = ST_ACTIVE;
               cnt_d      = '0;
               rx_shift_d = '0;
               do_load    = 1'b1;
            end
         end
         default: begin
            if (!cs_s) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               load_pend_d = 1'b0;
               skip_d      = 1'b0;
               und_pend_d  = 1'b0;
               frame_err_d = (cnt_q != '0);
            end else begin
               if (sample_edge) begin
                  rx_shift_d = rx_next;
                  // Underrun is reported once the empty word actually carries a bit,
                  // so a frame ending on a word boundary raises no phantom pulse
                  if (cnt_q == '0 && und_pend_q) begin
                     underrun_d = 1'b1;
                     und_pend_d = 1'b0;
                  end
                  if (cnt_q == CNT_W'(DATA_W - 1)) begin
                     cnt_d      = '0;
                     rx_data_d  = rx_next;
                     rx_valid_d = 1'b1;
                     if (LATE_SAMPLE) do_load     = 1'b1;
                     else             load_pend_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               if (shift_edge) begin
                  if (load_pend_q) begin
                     do_load     = 1'b1;
                     load_pend_d = 1'b0;
                  end else if (skip_q) begin
                     skip_d = 1'b0;
                  end else begin
                     tx_shift_d = tx_shifted;
                  end
               end
            end
         end
      endcase

      if (do_load) begin
         if (hold_full_q) begin
            tx_shift_d  = hold_q;
            hold_full_d = 1'b0;
         end else if (tx_load) begin
            tx_shift_d  = tx_data;
            hold_full_d = 1'b0;
         end else begin
            tx_shift_d = '0;
            und_pend_d = 1'b1;
         end
         // With late sampling the first bit is already on MISO, so the next shift edge is a no-op
         skip_d = LATE_SAMPLE;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         rx_data_q   <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         und_pend_q  <= 1'b0;
         frame_err_q <= 1'b0;
         load_pend_q <= 1'b0;
         skip_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         rx_data_q   <= rx_data_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
         und_pend_q  <= und_pend_d;
         frame_err_q <= frame_err_d;
         load_pend_q <= load_pend_d;
         skip_q      <= skip_d;
      end
   end

   assign busy        = (state_q == ST_ACTIVE);
   assign miso_oe     = busy;
   assign spi_miso    = busy & (MSB_F ? tx_shift_q[DATA_W-1] : tx_shift_q[0]);
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_ready    = ~hold_full_q;
   assign tx_underrun = underrun_q;
   assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// tb/tb_spi_slave_core.sv - scoreboard bench for spi_slave_core in three configurations
module tb_spi_slave_core;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [2:0] sclk, cs, mosi, txl;
   logic [2:0] miso, oe, rxv, txr, und, ferr, bsy;
   logic [7:0]  txd0, txd1, rxd0, rxd1;
   logic [15:0] txd2, rxd2;

   int n_tests = 0;
   int n_fail  = 0;
   int cnt_rxv[3];
   int cnt_und[3];
   int cnt_ferr[3];

   typedef struct {
      int          inst;
      logic [15:0] data;
   } exp_t;
   exp_t sb[$];

   int width_c[3] = '{8, 8, 16};
   bit cpol_c[3]  = '{1'b0, 1'b1, 1'b0};
   bit cpha_c[3]  = '{1'b0, 1'b1, 1'b1};
   bit msb_c[3]   = '{1'b1, 1'b1, 1'b0};

   // inst 0: mode 0, 8 bit, MSB first
   spi_slave_core #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m0 (
      .clk(clk), .rst(rst), .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_cs(cs[0]),
      .spi_miso(miso[0]), .miso_oe(oe[0]), .rx_data(rxd0), .rx_valid(rxv[0]),
      .tx_data(txd0), .tx_load(txl[0]), .tx_ready(txr[0]), .tx_underrun(und[0]),
      .frame_err(ferr[0]), .busy(bsy[0]));

   // inst 1: mode 3, 8 bit, MSB first
   spi_slave_core #(.DATA_W(8), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2)) u_m3 (
      .clk(clk), .rst(rst), .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_cs(cs[1]),
      .spi_miso(miso[1]), .miso_oe(oe[1]), .rx_data(rxd1), .rx_valid(rxv[1]),
      .tx_data(txd1), .tx_load(txl[1]), .tx_ready(txr[1]), .tx_underrun(und[1]),
      .frame_err(ferr[1]), .busy(bsy[1]));

   // inst 2: mode 1, 16 bit, LSB first
   spi_slave_core #(.DATA_W(16), .CPOL(0), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(2)) u_m1 (
      .clk(clk), .rst(rst), .spi_sclk(sclk[2]), .spi_mosi(mosi[2]), .spi_cs(cs[2]),
      .spi_miso(miso[2]), .miso_oe(oe[2]), .rx_data(rxd2), .rx_valid(rxv[2]),
      .tx_data(txd2), .tx_load(txl[2]), .tx_ready(txr[2]), .tx_underrun(und[2]),
      .frame_err(ferr[2]), .busy(bsy[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_rx(input int i);
      logic [15:0] got;
      exp_t        e;
      got = (i == 0) ? {8'h00, rxd0} : (i == 1) ? {8'h00, rxd1} : rxd2;
      check("rx_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("rx_inst", i, e.inst);
         check("rx_data", {16'h0, got}, {16'h0, e.data});
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rxv[i] === 1'b1) begin
            cnt_rxv[i]++;
            check_rx(i);
         end
         if (und[i] === 1'b1)  cnt_und[i]++;
         if (ferr[i] === 1'b1) cnt_ferr[i]++;
      end
   end

   task automatic half();
      repeat (8) @(negedge clk);
   endtask

   task automatic spi_bit(input int i, input logic b, output logic m);
      if (!cpha_c[i]) begin
         mosi[i] = b;
         half();
         m = miso[i];
         sclk[i] = ~cpol_c[i];
         half();
         sclk[i] = cpol_c[i];
      end else begin
         sclk[i] = ~cpol_c[i];
         mosi[i] = b;
         half();
         m = miso[i];
         sclk[i] = cpol_c[i];
         half();
      end
   endtask

   task automatic spi_word(input int i, input logic [15:0] w, output logic [15:0] r);
      int   idx;
      logic m;
      exp_t e;
      e.inst = i;
      e.data = w;
      sb.push_back(e);
      r = '0;
      for (int k = 0; k < width_c[i]; k++) begin
         idx = msb_c[i] ? width_c[i] - 1 - k : k;
         spi_bit(i, w[idx], m);
         r[idx] = m;
      end
   endtask

   task automatic cs_set(input int i, input logic v);
      if (!v) half();
      @(negedge clk);
      cs[i] = v;
      repeat (12) @(negedge clk);
   endtask

   task automatic tx_put(input int i, input logic [15:0] w);
      @(negedge clk);
      case (i)
         0:       txd0 = w[7:0];
         1:       txd1 = w[7:0];
         default: txd2 = w;
      endcase
      txl[i] = 1'b1;
      @(negedge clk);
      txl[i] = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      for (int i = 0; i < 3; i++) begin
         check({tag, "_flags"}, {25'h0, miso[i], oe[i], rxv[i], txr[i], und[i], ferr[i], bsy[i]},
               32'b0001000);
      end
      check({tag, "_rxd0"}, {24'h0, rxd0}, 32'h0);
      check({tag, "_rxd1"}, {24'h0, rxd1}, 32'h0);
      check({tag, "_rxd2"}, {16'h0, rxd2}, 32'h0);
   endtask

   initial begin
      logic [15:0] r, r2;
      logic        m;
      int          rxv0, und0, ferr0;

      sclk = 3'b010;
      cs   = 3'b000;
      mosi = 3'b000;
      txl  = 3'b000;
      txd0 = '0;
      txd1 = '0;
      txd2 = '0;
      rst  = 1'b1;
      repeat (5) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Mode 0 single word
      tx_put(0, 16'h3C);
      check("t1_tx_ready_low", txr[0], 1'b0);
      rxv0 = cnt_rxv[0]; ferr0 = cnt_ferr[0];
      cs_set(0, 1'b1);
      check("t1_busy", {oe[0], bsy[0]}, 2'b11);
      check("t1_tx_ready_back", txr[0], 1'b1);
      spi_word(0, 16'hA5, r);
      cs_set(0, 1'b0);
      check("t1_miso_word", r, 16'h3C);
      check("t1_rx_pulses", cnt_rxv[0] - rxv0, 1);
      check("t1_no_frame_err", cnt_ferr[0] - ferr0, 0);
      check("t1_idle", {oe[0], bsy[0]}, 2'b00);

      // Mode 3 single word
      tx_put(1, 16'hC3);
      rxv0 = cnt_rxv[1]; ferr0 = cnt_ferr[1];
      cs_set(1, 1'b1);
      spi_word(1, 16'h5A, r);
      cs_set(1, 1'b0);
      check("t2_miso_word", r, 16'hC3);
      check("t2_rx_pulses", cnt_rxv[1] - rxv0, 1);
      check("t2_no_frame_err", cnt_ferr[1] - ferr0, 0);

      // Back-to-back words, only the first one loaded
      tx_put(0, 16'h11);
      rxv0 = cnt_rxv[0]; und0 = cnt_und[0];
      cs_set(0, 1'b1);
      spi_word(0, 16'h22, r);
      spi_word(0, 16'h33, r2);
      cs_set(0, 1'b0);
      check("t3_miso_word1", r, 16'h11);
      check("t3_miso_word2", r2, 16'h00);
      check("t3_underrun_pulses", cnt_und[0] - und0, 1);
      check("t3_rx_pulses", cnt_rxv[0] - rxv0, 2);

      // Abort after 5 bits; a word loaded mid-frame survives the abort
      rxv0 = cnt_rxv[0]; ferr0 = cnt_ferr[0];
      cs_set(0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         spi_bit(0, k[0], m);
         if (k == 1) tx_put(0, 16'h66);
      end
      cs_set(0, 1'b0);
      check("t4_frame_err", cnt_ferr[0] - ferr0, 1);
      check("t4_no_rx", cnt_rxv[0] - rxv0, 0);
      check("t4_hold_kept", txr[0], 1'b0);
      cs_set(0, 1'b1);
      spi_word(0, 16'h81, r);
      cs_set(0, 1'b0);
      check("t4_miso_after_abort", r, 16'h66);

      // Reset mid-word, then a clean frame
      rxv0 = cnt_rxv[0];
      cs_set(0, 1'b1);
      for (int k = 0; k < 3; k++) spi_bit(0, 1'b1, m);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      cs[0] = 1'b0;
      sclk[0] = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("t5_in_reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("t5_no_rx_from_partial", cnt_rxv[0] - rxv0, 0);
      tx_put(0, 16'h5A);
      cs_set(0, 1'b1);
      spi_word(0, 16'hF0, r);
      cs_set(0, 1'b0);
      check("t5_miso_word", r, 16'h5A);

      // 16-bit LSB-first mode 1; second load while full is ignored
      tx_put(2, 16'hBEEF);
      check("t6_tx_ready_low", txr[2], 1'b0);
      tx_put(2, 16'hDEAD);
      check("t6_tx_ready_still_low", txr[2], 1'b0);
      rxv0 = cnt_rxv[2];
      cs_set(2, 1'b1);
      spi_word(2, 16'h1234, r);
      cs_set(2, 1'b0);
      check("t6_miso_word", r, 16'hBEEF);
      check("t6_rx_pulses", cnt_rxv[2] - rxv0, 1);

      repeat (10) @(negedge clk);
      check("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
